// File: rtl/execute_pkg.sv
// execute_pkg: shared widths, opcodes and operand/result bundle types
// for the execute unit and its two-requester arbiter.
package execute_pkg;
  localparam int XLEN = 32;
  localparam int OPC_W = 7;
  localparam int FUNC_W = 4;
  localparam int NREQ = 2;
  localparam logic [OPC_W-1:0] OPC_ALU = 7'b0000001;
  localparam logic [OPC_W-1:0] OPC_ALUI = 7'b0000010;
  localparam logic [OPC_W-1:0] OPC_BR = 7'b0000011;
  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [OPC_W-1:0] opcode;
    logic [FUNC_W-1:0] func;
  } op_bundle_t;
  typedef struct packed {
    logic [XLEN-1:0] sonuc;
    logic pc_update;
    logic we;
    logic hata;
  } rsp_bundle_t;
endpackage

// File: rtl/execute_rtl.sv
// execute_rtl: combinational execute unit; register/immediate ALU ops and
// conditional branches, flagging hata for unknown opcode/function codes.
module execute_rtl
  import execute_pkg::*;
#(
  parameter int DW = XLEN
) (
  input  logic [DW-1:0]     rs1_data,
  input  logic [DW-1:0]     rs2_data,
  input  logic [DW-1:0]     imm,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  output logic [DW-1:0]     sonuc,
  output logic              pc_update,
  output logic              we,
  output logic              hata
);
  logic [DW-1:0] b, alu;
  logic alu_ok, br_ok, is_alu, is_br, eq, lt, cond;
  always_comb begin
    b = opcode == OPC_ALUI ? imm : rs2_data;
    alu_ok = 1'b1;
    case (func)
      4'd0: alu = rs1_data + b;
      4'd1: alu = rs1_data - b;
      4'd2: alu = rs1_data & b;
      4'd3: alu = rs1_data | b;
      4'd4: alu = rs1_data ^ b;
      4'd5: alu = rs1_data << b[$clog2(DW)-1:0];
      4'd6: alu = rs1_data >> b[$clog2(DW)-1:0];
      4'd7: alu = DW'($signed(rs1_data) < $signed(b));
      default: begin
        alu = '0;
        alu_ok = 1'b0;
      end
    endcase
    // branches compare rs1/rs2 and report rs1+imm as the target
    eq = rs1_data == rs2_data;
    lt = $signed(rs1_data) < $signed(rs2_data);
    br_ok = func inside {4'd0, 4'd1, 4'd4, 4'd5};
    cond = func == 4'd0 ? eq : func == 4'd1 ? !eq : func == 4'd4 ? lt : !lt;
    is_alu = opcode == OPC_ALU || opcode == OPC_ALUI;
    is_br = opcode == OPC_BR;
    sonuc = (is_alu && alu_ok) ? alu : (is_br && br_ok) ? rs1_data + imm : '0;
    pc_update = is_br && br_ok && cond;
    we = is_alu && alu_ok;
    hata = is_alu ? !alu_ok : is_br ? !br_ok : 1'b1;
  end
endmodule

// File: rtl/execute_arbiter.sv
// execute_arbiter: round-robin sharing of one execute_rtl between two
// requesters, with an operand register, per-requester result buffers and error counters.
module execute_arbiter
  import execute_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int CW = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][DW-1:0]   req_rs1_data,
  input  logic [NREQ-1:0][DW-1:0]   req_rs2_data,
  input  logic [NREQ-1:0][DW-1:0]   req_imm,
  input  logic [NREQ-1:0][6:0]      req_opcode,
  input  logic [NREQ-1:0][3:0]      req_func,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [NREQ-1:0][DW-1:0]   rsp_sonuc,
  output logic [NREQ-1:0]           rsp_pc_update,
  output logic [NREQ-1:0]           rsp_we,
  output logic [NREQ-1:0]           rsp_hata,
  output logic [NREQ-1:0][CW-1:0]   err_count
);
  logic [NREQ-1:0] busy_q, busy_d, elig, grant, hs, cap, rsp_valid_q, rsp_valid_d;
  logic last_grant_q, last_grant_d, op_valid_q, op_owner_q;
  op_bundle_t op_q, op_d;
  rsp_bundle_t res;
  rsp_bundle_t [NREQ-1:0] buf_q, buf_d;
  logic [NREQ-1:0][CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] ex_sonuc;
  logic ex_pc, ex_we, ex_hata;
  execute_rtl #(.DW(DW)) u_exec (
    .rs1_data (op_q.rs1),
    .rs2_data (op_q.rs2),
    .imm      (op_q.imm),
    .opcode   (op_q.opcode),
    .func     (op_q.func),
    .sonuc    (ex_sonuc),
    .pc_update(ex_pc),
    .we       (ex_we),
    .hata     (ex_hata)
  );
  always_comb begin
    elig = req_valid & ~busy_q;
    grant = &elig ? (last_grant_q ? 2'b01 : 2'b10) : elig;
    hs = rsp_valid_q & rsp_ready;
    cap = op_valid_q ? (op_owner_q ? 2'b10 : 2'b01) : 2'b00;
    busy_d = grant | (busy_q & ~hs);
    last_grant_d = |grant ? grant[1] : last_grant_q;
    op_d = '{rs1: req_rs1_data[grant[1]], rs2: req_rs2_data[grant[1]], imm: req_imm[grant[1]],
             opcode: req_opcode[grant[1]], func: req_func[grant[1]]};
    res = '{sonuc: ex_sonuc, pc_update: ex_pc, we: ex_we, hata: ex_hata};
    // busy keeps a buffer empty until its result lands, so capture never collides with a hold
    rsp_valid_d = cap | (rsp_valid_q & ~rsp_ready);
    buf_d = buf_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      buf_d[i] = cap[i] ? res : buf_q[i];
      cnt_d[i] = cnt_q[i] + CW'(cap[i] && res.hata && !(&cnt_q[i]));
    end
  end
  always_comb begin
    req_ready = grant;
    rsp_valid = rsp_valid_q;
    err_count = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      rsp_sonuc[i] = buf_q[i].sonuc;
      rsp_pc_update[i] = buf_q[i].pc_update;
      rsp_we[i] = buf_q[i].we;
      rsp_hata[i] = buf_q[i].hata;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_q <= '0;
      last_grant_q <= 1'b1;
      op_valid_q <= 1'b0;
      op_owner_q <= 1'b0;
      op_q <= '0;
      buf_q <= '0;
      rsp_valid_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      last_grant_q <= last_grant_d;
      op_valid_q <= |grant;
      op_owner_q <= grant[1];
      op_q <= op_d;
      buf_q <= buf_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q <= cnt_d;
    end
endmodule
